// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial comparator path: the serializer
// FSM state encoding and widths that the comparator also relies on.
package cmp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Default operand width, shared with the downstream comparator.
   localparam int CMP_WIDTH  = 32;

   // Width of the completed-pair counter.
   localparam int PAIR_CNT_W = 8;

endpackage

// File: rtl/cmp_operand_shreg.sv
// Loadable WIDTH-bit shift register. Load wins over shift. The output bit
// is the end the data leaves from: MSB when MSB_FIRST=1, LSB otherwise.
// Vacated positions fill with zero, so a fully drained register reads 0.
module cmp_operand_shreg
   import cmp_pkg::*;
#(
   parameter int WIDTH     = CMP_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             shift,
   output logic             dout
);

   logic [WIDTH-1:0] sh_reg;
   logic [WIDTH-1:0] sh_shifted;

   if (MSB_FIRST) begin : g_msb
      assign sh_shifted = {sh_reg[WIDTH-2:0], 1'b0};
      assign dout       = sh_reg[WIDTH-1];
   end else begin : g_lsb
      assign sh_shifted = {1'b0, sh_reg[WIDTH-1:1]};
      assign dout       = sh_reg[0];
   end

   // Load a new operand or move one position toward the output end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_reg <= '0;
      end else if (load) begin
         sh_reg <= din;
      end else if (shift) begin
         sh_reg <= sh_shifted;
      end
   end

endmodule

// File: rtl/cmp_operand_serializer.sv
// Operand-pair serializer feeding the bit-serial magnitude comparator.
// One pair shifts out while a second waits in the pending register, so a
// continuous input stream produces a bubble-free bit stream.
module cmp_operand_serializer
   import cmp_pkg::*;
#(
   parameter int WIDTH     = CMP_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   output logic                  bit_valid,
   input  logic                  bit_ready,
   output logic                  bit_a,
   output logic                  bit_b,
   output logic                  bit_first,
   output logic                  bit_last,
   output logic                  busy,
   output logic [PAIR_CNT_W-1:0] pair_count
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    pd_valid_reg;
   logic [WIDTH-1:0]        pd_a_reg, pd_b_reg;
   logic [PAIR_CNT_W-1:0]   pair_count_reg;
   logic                    bit_first_reg, bit_last_reg;

   logic                    sh_valid;
   logic                    accept, xfer, last_xfer;
   logic                    sh_load, sh_src_pd, pd_load, pd_clear;
   logic [WIDTH-1:0]        load_a, load_b;

   assign sh_valid  = (state_reg == SHIFT);
   assign in_ready  = !pd_valid_reg;
   assign accept    = in_valid && in_ready;
   assign xfer      = sh_valid && bit_ready;
   assign last_xfer = xfer && (idx_reg == IDX_LAST);

   // Decide where an accepted pair goes and how the bit index advances.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      sh_load    = 1'b0;
      sh_src_pd  = 1'b0;
      pd_load    = 1'b0;
      pd_clear   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               sh_load    = 1'b1;
               idx_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_xfer) begin
               idx_next = '0;
               if (pd_valid_reg) begin
                  sh_load   = 1'b1;
                  sh_src_pd = 1'b1;
                  pd_clear  = 1'b1;
               end else if (accept) begin
                  // Nothing pending: the new pair goes straight to the shifter.
                  sh_load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               if (xfer) begin
                  idx_next = idx_reg + 1'b1;
               end
               if (accept) begin
                  pd_load = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state, index, pending flag, counter and registered markers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         pd_valid_reg   <= 1'b0;
         pair_count_reg <= '0;
         bit_first_reg  <= 1'b0;
         bit_last_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         bit_first_reg <= (state_next == SHIFT) && (idx_next == '0);
         bit_last_reg  <= (state_next == SHIFT) && (idx_next == IDX_LAST);
         if (pd_load) begin
            pd_valid_reg <= 1'b1;
         end else if (pd_clear) begin
            pd_valid_reg <= 1'b0;
         end
         if (last_xfer) begin
            pair_count_reg <= pair_count_reg + 1'b1;
         end
      end
   end

   // Pending operand storage, written only when a pair is parked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pd_a_reg <= '0;
         pd_b_reg <= '0;
      end else if (pd_load) begin
         pd_a_reg <= in_a;
         pd_b_reg <= in_b;
      end
   end

   assign load_a = sh_src_pd ? pd_a_reg : in_a;
   assign load_b = sh_src_pd ? pd_b_reg : in_b;

   cmp_operand_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg_a (
      .clk   (clk),
      .reset (reset),
      .load  (sh_load),
      .din   (load_a),
      .shift (xfer),
      .dout  (bit_a)
   );

   cmp_operand_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg_b (
      .clk   (clk),
      .reset (reset),
      .load  (sh_load),
      .din   (load_b),
      .shift (xfer),
      .dout  (bit_b)
   );

   assign bit_valid  = sh_valid;
   assign bit_first  = bit_first_reg;
   assign bit_last   = bit_last_reg;
   assign busy       = sh_valid || pd_valid_reg;
   assign pair_count = pair_count_reg;

endmodule

// File: tb/tb_cmp_operand_serializer.sv
// Directed bench for the operand serializer: an MSB-first instance for the
// main scenarios and an LSB-first instance for bit ordering.
module tb_cmp_operand_serializer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        m_in_valid = 1'b0, m_in_ready, m_bit_ready = 1'b1;
   logic [31:0] m_in_a = '0, m_in_b = '0;
   logic        m_bit_valid, m_bit_a, m_bit_b, m_bit_first, m_bit_last, m_busy;
   logic [7:0]  m_pair_count;

   logic        l_in_valid = 1'b0, l_in_ready, l_bit_ready = 1'b1;
   logic [31:0] l_in_a = '0, l_in_b = '0;
   logic        l_bit_valid, l_bit_a, l_bit_b, l_bit_first, l_bit_last, l_busy;
   logic [7:0]  l_pair_count;

   int errors = 0;
   int checks = 0;

   cmp_operand_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(m_in_a), .in_b(m_in_b),
      .bit_valid(m_bit_valid), .bit_ready(m_bit_ready), .bit_a(m_bit_a), .bit_b(m_bit_b),
      .bit_first(m_bit_first), .bit_last(m_bit_last), .busy(m_busy), .pair_count(m_pair_count)
   );

   cmp_operand_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset),
      .in_valid(l_in_valid), .in_ready(l_in_ready), .in_a(l_in_a), .in_b(l_in_b),
      .bit_valid(l_bit_valid), .bit_ready(l_bit_ready), .bit_a(l_bit_a), .bit_b(l_bit_b),
      .bit_first(l_bit_first), .bit_last(l_bit_last), .busy(l_busy), .pair_count(l_pair_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      m_in_valid = 1'b0; l_in_valid = 1'b0;
      m_bit_ready = 1'b1; l_bit_ready = 1'b1;
      tick;
      @(posedge clk);
      #3 reset = 1'b1;
      tick;
   endtask

   task automatic send_m(input logic [31:0] a, input logic [31:0] b);
      m_in_a = a; m_in_b = b; m_in_valid = 1'b1;
      tick;
      m_in_valid = 1'b0;
      $display("accept msb a=%08h b=%08h", a, b);
   endtask

   task automatic test_reset;
      do_reset;
      send_m(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick; tick; tick;
      checks++;
      if ({m_bit_valid, m_bit_a, m_bit_b, m_busy} !== 4'b1111) begin
         errors++; $display("FAIL reset_pre: got %b expected 1111", {m_bit_valid, m_bit_a, m_bit_b, m_busy});
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({m_bit_valid, m_bit_a, m_bit_b, m_bit_first, m_bit_last, m_busy, m_in_ready} !== 7'b0000001) begin
         errors++; $display("FAIL reset_outputs: got %b expected 0000001",
                            {m_bit_valid, m_bit_a, m_bit_b, m_bit_first, m_bit_last, m_busy, m_in_ready});
      end
      checks++;
      if (m_pair_count !== 8'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", m_pair_count);
      end
      @(posedge clk);
      #3 reset = 1'b1;
      tick;
   endtask

   task automatic test_single;
      int n = 0, ab_diff = 0, bad_first = 0, bad_last = 0;
      logic [31:0] ca = '0, cb = '0;
      do_reset;
      send_m(32'd50, 32'd50);
      checks++;
      if ({m_bit_valid, m_bit_first} !== 2'b11) begin
         errors++; $display("FAIL single_latency: got %b expected 11", {m_bit_valid, m_bit_first});
      end
      for (int c = 0; c < 100 && n < 32; c++) begin
         if (m_bit_valid && m_bit_ready) begin
            ca = {ca[30:0], m_bit_a}; cb = {cb[30:0], m_bit_b};
            if (m_bit_a !== m_bit_b) ab_diff++;
            if (m_bit_first !== (n == 0)) bad_first++;
            if (m_bit_last !== (n == 31)) bad_last++;
            n++;
         end
         tick;
      end
      $display("pair msb a=%08h b=%08h transfers=%0d", ca, cb, n);
      checks++;
      if (n !== 32) begin errors++; $display("FAIL single_transfers: got %0d expected 32", n); end
      checks++;
      if (ca !== 32'd50 || cb !== 32'd50) begin
         errors++; $display("FAIL single_bits: got a=%08h b=%08h expected 00000032", ca, cb);
      end
      checks++;
      if (ab_diff !== 0) begin errors++; $display("FAIL single_ab_equal: got %0d diffs expected 0", ab_diff); end
      checks++;
      if (bad_first !== 0 || bad_last !== 0) begin
         errors++; $display("FAIL single_markers: got first_err=%0d last_err=%0d expected 0", bad_first, bad_last);
      end
      checks++;
      if (m_pair_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", m_pair_count); end
      checks++;
      if ({m_busy, m_bit_valid} !== 2'b00) begin
         errors++; $display("FAIL single_idle: got %b expected 00", {m_busy, m_bit_valid});
      end
   endtask

   task automatic test_back_to_back;
      int n = 0, gaps = 0, bad_first = 0, bad_last = 0, rdy_bad = 0;
      logic [31:0] ca1 = '0, cb1 = '0, ca2 = '0, cb2 = '0;
      do_reset;
      m_in_a = 32'hFFFF_0000; m_in_b = 32'h0000_FFFF; m_in_valid = 1'b1;
      tick;
      for (int k = 0; k < 80 && n < 64; k++) begin
         if (k == 0) begin
            m_in_a = 32'd7; m_in_b = 32'd9; m_in_valid = 1'b1;
         end else begin
            m_in_valid = 1'b0;
         end
         if (!m_bit_valid) gaps++;
         if (k >= 1 && k <= 31 && m_in_ready !== 1'b0) rdy_bad++;
         if (k == 32 && m_in_ready !== 1'b1) rdy_bad++;
         if (m_bit_valid && m_bit_ready) begin
            if (n < 32) begin ca1 = {ca1[30:0], m_bit_a}; cb1 = {cb1[30:0], m_bit_b}; end
            else        begin ca2 = {ca2[30:0], m_bit_a}; cb2 = {cb2[30:0], m_bit_b}; end
            if (m_bit_first !== (n == 0 || n == 32)) bad_first++;
            if (m_bit_last !== (n == 31 || n == 63)) bad_last++;
            n++;
         end
         tick;
      end
      $display("pair msb a=%08h b=%08h", ca1, cb1);
      $display("pair msb a=%08h b=%08h", ca2, cb2);
      checks++;
      if (n !== 64 || gaps !== 0) begin
         errors++; $display("FAIL b2b_stream: got transfers=%0d gaps=%0d expected 64 and 0", n, gaps);
      end
      checks++;
      if (ca1 !== 32'hFFFF_0000 || cb1 !== 32'h0000_FFFF) begin
         errors++; $display("FAIL b2b_pair1: got a=%08h b=%08h expected ffff0000 0000ffff", ca1, cb1);
      end
      checks++;
      if (ca2 !== 32'd7 || cb2 !== 32'd9) begin
         errors++; $display("FAIL b2b_pair2: got a=%08h b=%08h expected 00000007 00000009", ca2, cb2);
      end
      checks++;
      if (bad_first !== 0 || bad_last !== 0) begin
         errors++; $display("FAIL b2b_markers: got first_err=%0d last_err=%0d expected 0", bad_first, bad_last);
      end
      checks++;
      if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_in_ready: got %0d bad cycles expected 0", rdy_bad); end
      checks++;
      if (m_pair_count !== 8'd2 || m_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_count: got count=%0d busy=%b expected 2 0", m_pair_count, m_busy);
      end
   endtask

   task automatic test_backpressure;
      int n = 0, freeze_bad = 0;
      bit held = 0;
      logic [31:0] ca = '0, cb = '0;
      do_reset;
      send_m(32'h0020_0000, 32'hFFDF_FFFF);
      for (int k = 0; k < 100 && n < 32; k++) begin
         if (n == 10 && !held) begin
            m_bit_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick;
               if ({m_bit_valid, m_bit_a, m_bit_b, m_bit_first, m_bit_last} !== 5'b11000) freeze_bad++;
            end
            m_bit_ready = 1'b1;
            held = 1;
         end
         if (m_bit_valid && m_bit_ready) begin
            ca = {ca[30:0], m_bit_a}; cb = {cb[30:0], m_bit_b};
            n++;
         end
         tick;
      end
      $display("pair msb a=%08h b=%08h transfers=%0d (stalled)", ca, cb, n);
      checks++;
      if (freeze_bad !== 0) begin errors++; $display("FAIL bp_freeze: got %0d bad cycles expected 0", freeze_bad); end
      checks++;
      if (n !== 32) begin errors++; $display("FAIL bp_transfers: got %0d expected 32", n); end
      checks++;
      if (ca !== 32'h0020_0000 || cb !== 32'hFFDF_FFFF) begin
         errors++; $display("FAIL bp_bits: got a=%08h b=%08h expected 00200000 ffdfffff", ca, cb);
      end
      checks++;
      if (m_pair_count !== 8'd1) begin errors++; $display("FAIL bp_count: got %0d expected 1", m_pair_count); end
   endtask

   task automatic test_reset_midstream;
      int n = 0;
      logic [31:0] ca = '0, cb = '0;
      do_reset;
      m_in_a = 32'hFFFF_FFFF; m_in_b = 32'hFFFF_FFFF; m_in_valid = 1'b1;
      tick;
      m_in_a = 32'h1234_5678; m_in_b = 32'h8765_4321;
      tick;
      m_in_valid = 1'b0;
      for (int k = 0; k < 11; k++) tick;
      checks++;
      if ({m_busy, m_in_ready, m_bit_valid} !== 3'b101) begin
         errors++; $display("FAIL rst_mid_pre: got %b expected 101", {m_busy, m_in_ready, m_bit_valid});
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({m_bit_valid, m_bit_a, m_bit_b, m_bit_first, m_bit_last, m_busy, m_in_ready} !== 7'b0000001
          || m_pair_count !== 8'd0) begin
         errors++; $display("FAIL rst_mid_clear: got %b count=%0d expected 0000001 count=0",
                            {m_bit_valid, m_bit_a, m_bit_b, m_bit_first, m_bit_last, m_busy, m_in_ready},
                            m_pair_count);
      end
      @(posedge clk);
      #3 reset = 1'b1;
      tick;
      checks++;
      if ({m_bit_valid, m_busy} !== 2'b00) begin
         errors++; $display("FAIL rst_mid_discard: got %b expected 00", {m_bit_valid, m_busy});
      end
      send_m(32'd3, 32'd5);
      checks++;
      if ({m_bit_valid, m_bit_first} !== 2'b11) begin
         errors++; $display("FAIL rst_mid_restart: got %b expected 11", {m_bit_valid, m_bit_first});
      end
      for (int c = 0; c < 100 && n < 32; c++) begin
         if (m_bit_valid && m_bit_ready) begin
            ca = {ca[30:0], m_bit_a}; cb = {cb[30:0], m_bit_b};
            n++;
         end
         tick;
      end
      $display("pair msb a=%08h b=%08h transfers=%0d", ca, cb, n);
      checks++;
      if (n !== 32 || ca !== 32'd3 || cb !== 32'd5 || m_pair_count !== 8'd1) begin
         errors++; $display("FAIL rst_mid_after: got n=%0d a=%08h b=%08h count=%0d expected 32 3 5 1",
                            n, ca, cb, m_pair_count);
      end
   endtask

   task automatic test_lsb_first;
      int n = 0;
      logic fa = 1'bx, fb = 1'bx, la = 1'bx, lb = 1'bx;
      logic [31:0] ca = '0, cb = '0;
      do_reset;
      l_in_a = 32'd1; l_in_b = 32'h8000_0000; l_in_valid = 1'b1;
      tick;
      l_in_valid = 1'b0;
      for (int c = 0; c < 100 && n < 32; c++) begin
         if (l_bit_valid && l_bit_ready) begin
            ca = {l_bit_a, ca[31:1]}; cb = {l_bit_b, cb[31:1]};
            if (n == 0)  begin fa = l_bit_a; fb = l_bit_b; end
            if (n == 31) begin la = l_bit_a; lb = l_bit_b; end
            n++;
         end
         tick;
      end
      $display("pair lsb a=%08h b=%08h transfers=%0d", ca, cb, n);
      checks++;
      if ({fa, fb} !== 2'b10) begin errors++; $display("FAIL lsb_first_bit: got %b expected 10", {fa, fb}); end
      checks++;
      if ({la, lb} !== 2'b01) begin errors++; $display("FAIL lsb_last_bit: got %b expected 01", {la, lb}); end
      checks++;
      if (n !== 32 || ca !== 32'd1 || cb !== 32'h8000_0000 || l_pair_count !== 8'd1) begin
         errors++; $display("FAIL lsb_stream: got n=%0d a=%08h b=%08h count=%0d expected 32 1 80000000 1",
                            n, ca, cb, l_pair_count);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_reset_midstream;
      test_lsb_first;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
